// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - CPU load/store unit with byte/half read-modify-write onto a word memory
module mem_access_unit #(
    parameter int MEM_WORDS = 3072
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [29:0] MEM_WORDS_L = 30'(MEM_WORDS);

    logic [1:0]  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        sext_q, sext_d;
    logic [31:0] wdata_q, wdata_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] rmw_q, rmw_d;

    logic        reject;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_val;
    logic [31:0] merged;

    // Request validity is judged on the raw inputs so a rejection costs no memory cycle.
    always_comb begin
        reject = 1'b0;
        if (size == 2'b11)
            reject = 1'b1;
        if (size == SZ_HALF && addr[0])
            reject = 1'b1;
        if (size == SZ_WORD && addr[1:0] != 2'b00)
            reject = 1'b1;
        if (addr[31:2] >= MEM_WORDS_L)
            reject = 1'b1;
    end

    always_comb begin
        byte_sel = 8'h00;
        case (addr_q[1:0])
            2'd0: byte_sel = mem_rdata[7:0];
            2'd1: byte_sel = mem_rdata[15:8];
            2'd2: byte_sel = mem_rdata[23:16];
            2'd3: byte_sel = mem_rdata[31:24];
            default: byte_sel = 8'h00;
        endcase
        half_sel = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (size_q)
            SZ_BYTE: load_val = {{24{sext_q & byte_sel[7]}}, byte_sel};
            SZ_HALF: load_val = {{16{sext_q & half_sel[15]}}, half_sel};
            default: load_val = mem_rdata;
        endcase
    end

    // Partial stores replace only the target lane of the word captured during READ.
    always_comb begin
        merged = rmw_q;
        if (size_q == SZ_BYTE)
            merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        else if (size_q == SZ_HALF)
            merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        we_d    = we_q;
        size_d  = size_q;
        sext_d  = sext_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        rmw_d   = rmw_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    addr_d  = addr;
                    we_d    = we;
                    size_d  = size;
                    sext_d  = sext;
                    wdata_d = wdata;
                    err_d   = reject;
                    if (reject)
                        state_d = S_DONE;
                    else if (we && size == SZ_WORD)
                        state_d = S_WRITE;
                    else
                        state_d = S_READ;
                end
            end
            S_READ: begin
                if (we_q) begin
                    rmw_d   = mem_rdata;
                    state_d = S_WRITE;
                end else begin
                    rdata_d = load_val;
                    state_d = S_DONE;
                end
            end
            S_WRITE: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= 32'h0;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            sext_q  <= 1'b0;
            wdata_q <= 32'h0;
            err_q   <= 1'b0;
            rdata_q <= 32'h0;
            rmw_q   <= 32'h0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            size_q  <= size_d;
            sext_q  <= sext_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            rmw_q   <= rmw_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign err       = err_q;
    assign rdata     = rdata_q;
    assign mem_we    = (state_q == S_WRITE);
    assign mem_addr  = {addr_q[31:2], 2'b00};
    assign mem_wdata = (size_q == SZ_WORD) ? wdata_q : merged;

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 3072: number of 32-bit words in the attached data memory.
REQ-002 SHALL have port clk  input  1: single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1: asynchronous, active-high reset.
REQ-004 SHALL have port req  input  1: CPU access request.
REQ-005 SHALL have port we  input  1: 1 = store, 0 = load.
REQ-006 SHALL have port size  input  2: 00 byte, 01 halfword, 10 word, 11 reserved.
REQ-007 SHALL have port sext  input  1: load result sign-extended (1) or zero-extended (0).
REQ-008 SHALL have port addr  input  32: byte address.
REQ-009 SHALL have port wdata  input  32: store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-010 SHALL have port busy  output  1: high whenever state is not IDLE.
REQ-011 SHALL have port done  output  1: one-cycle completion pulse.
REQ-012 SHALL have port err  output  1: last transaction was rejected.
REQ-013 SHALL have port rdata  output  32: extended load result.
REQ-014 SHALL have port mem_we  output  1: memory write enable.
REQ-015 SHALL have port mem_addr  output  32: word-aligned memory address, {addr_q[31:2],2'b00}.
REQ-016 SHALL have port mem_wdata  output  32: full word to write.
REQ-017 SHALL have port mem_rdata  input  32: combinational read data for mem_addr; the memory writes on the rising edge when mem_we=1.

Function
REQ-018 SHALL implement states IDLE, READ, WRITE, DONE.
REQ-019 SHALL accept a request only when req=1 in IDLE, latching addr, we, size, sext, and wdata; a req while busy SHALL be ignored, not queued.
REQ-020 SHALL reject a request on the accept edge and go IDLE->DONE with err=1 and no memory write when any of these hold: size=11; half access with addr[0]=1; word access with addr[1:0]!=0; addr[31:2]>=MEM_WORDS.
REQ-021 Load: IDLE->READ->DONE->IDLE; on the READ->DONE edge rdata SHALL capture the selected lane of mem_rdata, extended per sext.
REQ-022 Word store: IDLE->WRITE->DONE->IDLE, with mem_wdata=wdata_q.
REQ-023 Byte/half store (read-modify-write): IDLE->READ->WRITE->DONE->IDLE; on the READ->WRITE edge the unit SHALL latch mem_rdata, and in WRITE mem_wdata SHALL be the latched word with only the target lane replaced.
REQ-024 Lane mapping SHALL be little-endian: byte lane k = bits [8k+7:8k] with k=addr[1:0]; the half lane is [15:0] when addr[1]=0 and [31:16] when addr[1]=1.
REQ-025 mem_we SHALL be 1 only in WRITE, for exactly one cycle per store.
REQ-026 done SHALL be 1 only in DONE; latency from the accept edge to done high SHALL be 1 cycle for a rejected request, 2 for a load or word store, and 3 for a byte/half store.
REQ-027 rdata SHALL hold its value until the next successful load completes; err SHALL hold until the next accept, where it updates.
REQ-028 A req asserted in the DONE cycle SHALL be ignored; a req in the following IDLE cycle SHALL be accepted.
REQ-029 In IDLE, mem_addr SHALL reflect the last latched address; mem_wdata is don't-care outside WRITE.

Reset
REQ-030 While reset=1, the unit SHALL immediately force state=IDLE, busy=0, done=0, err=0, rdata=0, mem_we=0, and all latched request fields to 0, independent of clk.
REQ-031 Reset asserted mid-transaction SHALL abort it with no memory write (mem_we drops combinationally) and no done pulse; the first accept SHALL occur on the first clk edge after reset deasserts with req=1.

Verification
REQ-032 Word store then load: sw addr=0x10, wdata=0x12345678 -> mem_we for 1 cycle with mem_addr=0x10; then lw addr=0x10 -> rdata=0x12345678, done 2 cycles after accept.
REQ-033 Byte RMW: word 0x10=0x12345678, sb addr=0x11, wdata=0xAB -> written word 0x1234AB78, done 3 cycles after accept; lb addr=0x11 with sext=1 -> rdata=0xFFFFFFAB; lbu -> 0x000000AB.
REQ-034 Half: sh addr=0x12, wdata=0x8001 onto 0x1234AB78 -> 0x8001AB78; lh addr=0x12 with sext=1 -> 0xFFFF8001.
REQ-035 Errors: lw addr=0x13, sh addr=0x11, size=11, and lw addr=4*MEM_WORDS -> each gives err=1 and done 1 cycle after accept, mem_we never 1, memory unchanged.
REQ-036 Reset during the WRITE cycle of an sb to 0x20 (word=0xFFFFFFFF) -> mem_we falls at once, word stays 0xFFFFFFFF, all outputs return to their reset values, no done pulse.
REQ-037 Back-to-back: req held high continuously -> no accept in READ/WRITE/DONE; each new accept occurs exactly one cycle after done.
